// File: rtl/wb_arbiter_rr2.sv
// Two-master round-robin Wishbone arbiter with a stalled-strobe watchdog.
// A grant is held for the winning master's whole cyc window. The slave
// response is forwarded only to that master. A strobe left unacked for
// TIMEOUT_CYCLES cycles is aborted with a one-cycle err pulse.
module wb_arbiter_rr2 #(
    parameter int ADDR_WIDTH     = 16,
    parameter int DATA_WIDTH     = 8,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  rst_n,
    // master 0 (SPI bridge)
    input  logic [ADDR_WIDTH-1:0] m0_adr_i,
    input  logic [DATA_WIDTH-1:0] m0_dat_i,
    input  logic                  m0_we_i,
    input  logic                  m0_cyc_i,
    input  logic                  m0_stb_i,
    output logic [DATA_WIDTH-1:0] m0_dat_o,
    output logic                  m0_ack_o,
    output logic                  m0_err_o,
    // master 1
    input  logic [ADDR_WIDTH-1:0] m1_adr_i,
    input  logic [DATA_WIDTH-1:0] m1_dat_i,
    input  logic                  m1_we_i,
    input  logic                  m1_cyc_i,
    input  logic                  m1_stb_i,
    output logic [DATA_WIDTH-1:0] m1_dat_o,
    output logic                  m1_ack_o,
    output logic                  m1_err_o,
    // slave
    output logic [ADDR_WIDTH-1:0] s_adr_o,
    output logic [DATA_WIDTH-1:0] s_dat_o,
    output logic                  s_we_o,
    output logic                  s_cyc_o,
    output logic                  s_stb_o,
    input  logic [DATA_WIDTH-1:0] s_dat_i,
    input  logic                  s_ack_i,
    // status
    output logic [1:0]            grant_o,
    output logic [7:0]            err_count_o
);

    typedef enum logic [1:0] {IDLE, GRANT, ABORT} state_t;

    localparam bit         WD_EN = (TIMEOUT_CYCLES != 0);
    localparam logic [7:0] WD_TO = 8'(TIMEOUT_CYCLES);

    state_t     state_q, state_d;
    logic       gnt_idx_q, gnt_idx_d;
    logic       last_idx_q, last_idx_d;
    logic [7:0] wd_cnt_q, wd_cnt_d;
    logic [1:0] err_q, err_d;
    logic [7:0] err_cnt_q, err_cnt_d;

    logic in_grant, gnt_cyc, gnt_stb, gnt_we, stall, wd_hit, pick;

    // Granted master's request lines and the slave-side mux
    always_comb begin
        in_grant = (state_q == GRANT);
        gnt_cyc  = gnt_idx_q ? m1_cyc_i : m0_cyc_i;
        gnt_stb  = gnt_idx_q ? m1_stb_i : m0_stb_i;
        gnt_we   = gnt_idx_q ? m1_we_i  : m0_we_i;
        s_adr_o  = gnt_idx_q ? m1_adr_i : m0_adr_i;
        s_dat_o  = gnt_idx_q ? m1_dat_i : m0_dat_i;
        s_cyc_o  = in_grant & gnt_cyc;
        s_stb_o  = in_grant & gnt_cyc & gnt_stb;
        s_we_o   = in_grant & gnt_cyc & gnt_we;
        // ack only reaches the granted master, and never outside GRANT so a
        // late ack during ABORT cannot collide with the err pulse
        m0_ack_o = in_grant & ~gnt_idx_q & s_ack_i;
        m1_ack_o = in_grant &  gnt_idx_q & s_ack_i;
        m0_dat_o = s_dat_i;
        m1_dat_o = s_dat_i;
        m0_err_o = err_q[0];
        m1_err_o = err_q[1];
        grant_o  = (state_q == IDLE) ? 2'b00 : (gnt_idx_q ? 2'b10 : 2'b01);
        err_count_o = err_cnt_q;
    end

    // Next-state, arbitration and watchdog decisions
    always_comb begin
        state_d    = state_q;
        gnt_idx_d  = gnt_idx_q;
        last_idx_d = last_idx_q;
        wd_cnt_d   = 8'd0;
        err_d      = 2'b00;
        err_cnt_d  = err_cnt_q;
        stall      = s_stb_o & ~s_ack_i;
        // fires on the edge where the count would reach the limit; an ack in
        // that cycle clears stall, so the ack wins
        wd_hit     = WD_EN && stall && ((wd_cnt_q + 8'd1) == WD_TO);
        pick       = (m0_cyc_i && m1_cyc_i) ? ~last_idx_q : m1_cyc_i;
        case (state_q)
            IDLE: begin
                if (m0_cyc_i || m1_cyc_i) begin
                    state_d    = GRANT;
                    gnt_idx_d  = pick;
                    last_idx_d = pick;
                end
            end
            GRANT: begin
                if (!gnt_cyc) begin
                    state_d = IDLE;
                end else if (wd_hit) begin
                    state_d           = ABORT;
                    err_d[gnt_idx_q]  = 1'b1;
                    if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
                end else if (WD_EN && stall) begin
                    wd_cnt_d = wd_cnt_q + 8'd1;
                end
            end
            ABORT: begin
                if (!gnt_cyc) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers; last_idx resets to 1 so master 0 wins the first tie
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            gnt_idx_q  <= 1'b0;
            last_idx_q <= 1'b1;
            wd_cnt_q   <= 8'd0;
            err_q      <= 2'b00;
            err_cnt_q  <= 8'd0;
        end else begin
            state_q    <= state_d;
            gnt_idx_q  <= gnt_idx_d;
            last_idx_q <= last_idx_d;
            wd_cnt_q   <= wd_cnt_d;
            err_q      <= err_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

endmodule

// File: doc/wb_arbiter_rr2.md
# wb_arbiter_rr2

Two-master round-robin Wishbone arbiter that lets two masters share one Wishbone slave. The masters are the SPI-to-Wishbone bridge and a second on-chip master such as a soft CPU or DMA, and the slave is typically the register block. It holds a grant for a master's whole `cyc` window, forwards `ack` only to the granted master, and aborts hung cycles with a watchdog that returns `err`. It sits between the masters' Wishbone ports and the slave's `wb_*_i` ports.

## Interface
- `ADDR_WIDTH`, 16, address width, pass-through.
- `DATA_WIDTH`, 8, data width, pass-through.
- `TIMEOUT_CYCLES`, 255, unacked-strobe cycles before abort; range 1–255; 0 disables the watchdog.
- `clk`  in  1  system clock; single clock domain.
- `rst_n`  in  1  asynchronous, active-low reset.
- `m0_adr_i`, `m0_dat_i`, `m0_we_i`, `m0_cyc_i`, `m0_stb_i`  in  ADDR_WIDTH / DATA_WIDTH / 1 / 1 / 1  master 0 request. Master 0 is the SPI bridge.
- `m0_dat_o`  out  DATA_WIDTH  read data to master 0.
- `m0_ack_o`, `m0_err_o`  out  1  handshake to master 0.
- `m1_*`  same set as `m0_*`  master 1 ports.
- `s_adr_o`, `s_dat_o`, `s_we_o`, `s_cyc_o`, `s_stb_o`  out  ADDR_WIDTH / DATA_WIDTH / 1 / 1 / 1  slave request.
- `s_dat_i`, `s_ack_i`  in  DATA_WIDTH / 1  slave response.
- `grant_o`  out  2  one-hot current grant; 00 means idle.
- `err_count_o`  out  8  saturating count of watchdog aborts.

## Operation
- State machine has three states: IDLE, GRANT, ABORT. A `gnt_idx` register selects the master and a `last_idx` register holds the previous winner.
- Reset values:
  - State is IDLE.
  - `last_idx` is 1, so master 0 wins the first contention.
  - `grant_o`, `err_count_o` and the watchdog counter are 0.
  - `s_cyc_o`, `s_stb_o`, `s_we_o`, every `ack_o` and every `err_o` are 0.
- IDLE:
  - `s_cyc_o`/`s_stb_o` are 0.
  - On a clock edge, if exactly one `mX_cyc_i` is high, go to GRANT with that master.
  - If both are high, grant the master that is not `last_idx`.
  - Update `last_idx` on every grant.
- GRANT:
  - `s_adr_o`, `s_dat_o`, `s_we_o`, `s_cyc_o`, `s_stb_o` are combinationally muxed from the granted master.
  - `mX_ack_o = s_ack_i` for the granted master and 0 for the other.
  - The grant is held while the granted `cyc_i` is high, covering multi-beat and read-modify-write cycles; the other master waits.
  - When the granted `cyc_i` is sampled low, go to IDLE.
- `s_dat_i` is broadcast to both `mX_dat_o`; `ack` qualifies it.
- Watchdog, only when `TIMEOUT_CYCLES` is nonzero:
  - The counter increments each GRANT cycle with `s_stb_o` high and `s_ack_i` low.
  - It clears on `s_ack_i`, on `s_stb_o` low, and on leaving GRANT.
  - On the edge where the count reaches `TIMEOUT_CYCLES`, go to ABORT. On that same edge, register a one-cycle `err_o` pulse to the granted master and increment `err_count_o`, saturating at 255.
  - If `ack` arrives in the cycle that would complete the count, the `ack` wins and no abort occurs.
- ABORT:
  - `s_cyc_o`/`s_stb_o` are forced to 0.
  - A late `s_ack_i` is not forwarded.
  - `grant_o` is unchanged.
  - Go to IDLE when the granted `cyc_i` is sampled low.
- A master's `err_o` and `ack_o` are never high in the same cycle.
- `cyc_i` dropped by the non-granted master has no effect.

## Timing
- Grant latency: `s_cyc_o` rises one cycle after `mX_cyc_i` is first sampled in IDLE.
- The `ack` path is combinational, with zero added latency.
- Handover: at least one IDLE cycle with `s_cyc_o` = 0 between consecutive grants.
- Under continuous contention, the masters alternate.
- `rst_n` low clears all state and outputs immediately, asynchronously, including mid-GRANT and mid-ABORT.
- After deassertion, the first edge can grant.
- The watchdog abort fires `TIMEOUT_CYCLES` unacked strobe cycles after the strobe starts. `err_o` is high in the following cycle.

## Test plan
- Master 0 alone writes 0xAA to 0x0005:
  - `s_cyc_o` rises 1 cycle after `m0_cyc_i`, with `s_adr_o`=0x0005 and `s_dat_o`=0xAA.
  - `m0_ack_o` equals `s_ack_i`; `m1_ack_o` stays 0.
  - The readback returns 0xAA on `m0_dat_o`.
- Both masters raise `cyc` in the same cycle after reset:
  - `grant_o`=01 first.
  - After `m0_cyc_i` drops, one idle cycle, then `grant_o`=10.
  - The next simultaneous request grants master 0 again.
- Locked cycle: master 0 holds `cyc` through 3 acked strobes while master 1 requests. `grant_o` stays 01 until `m0_cyc_i` falls, then switches to 10 after one idle cycle.
- Watchdog, with `TIMEOUT_CYCLES`=4 and a slave that never acks:
  - After 4 strobe cycles, `m0_err_o` pulses for 1 cycle and `s_cyc_o` goes low.
  - `err_count_o`=1.
  - A late `ack` is ignored.
  - After `m0_cyc_i` drops, a pending master 1 is granted.
- Watchdog boundary, with `TIMEOUT_CYCLES`=4: the slave acks in the 4th strobe cycle. No `err_o`, `err_count_o` stays 0, and the `ack` is forwarded.
- Reset mid-GRANT to master 1:
  - `rst_n` low immediately forces `s_cyc_o`=0, `grant_o`=00 and `err_count_o`=0.
  - After release, a simultaneous request grants master 0.
